// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
// Holds the fetch program counter and turns the 2-bit next-PC select coming
// from the jump/branch controller into instruction-memory requests. Wrong-path
// fetches that overlap a redirect are squashed, and decode gets a one-cycle
// flush pulse. The reset is synchronous and active-low.
module pc_fetch_sequencer #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       pc_sel,
  input  logic             sel_valid,
  input  logic [15:0]      branch_off,
  input  logic [25:0]      jump_target,
  input  logic [WIDTH-1:0] reg_target,
  input  logic             stall,
  input  logic             imem_ack,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  output logic             fetch_valid,
  output logic [WIDTH-1:0] dec_pc,
  output logic             flush
);

  // Next-PC select encodings from the jump/branch controller.
  localparam logic [1:0] SEL_SEQ    = 2'b00;
  localparam logic [1:0] SEL_BRANCH = 2'b01;
  localparam logic [1:0] SEL_REG    = 2'b10;
  localparam logic [1:0] SEL_JUMP   = 2'b11;

  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_FETCH = 2'd1,
    S_PEND  = 2'd2,
    S_IDLE  = 2'd3
  } state_t;

  state_t           state_r;
  state_t           next_state_s;

  logic [WIDTH-1:0] pc_r;
  logic [WIDTH-1:0] pc_next_s;
  logic [WIDTH-1:0] redir_pc_r;
  logic [WIDTH-1:0] redir_pc_next_s;
  logic [WIDTH-1:0] dec_pc_r;
  logic [WIDTH-1:0] dec_pc_next_s;
  logic             imem_req_r;
  logic             flush_r;
  logic             flush_next_s;

  logic             redirect_s;
  logic             ack_s;
  logic [WIDTH-1:0] dec_pc4_s;
  logic [WIDTH-1:0] branch_disp_s;
  logic [WIDTH-1:0] target_s;

  // Only bits [WIDTH-1:2] of a register target form a word address.
  logic             unused_reg_lsb_s;
  assign unused_reg_lsb_s = ^reg_target[1:0];

  // Sign-extend the word offset and convert it to a byte displacement.
  function automatic logic [WIDTH-1:0] branch_disp(input logic [15:0] off);
    branch_disp = {{(WIDTH - 18){off[15]}}, off, 2'b00};
  endfunction

  // Redirect request and the target it selects, relative to the decode PC.
  always_comb begin
    redirect_s    = sel_valid & (pc_sel != SEL_SEQ);
    dec_pc4_s     = dec_pc_r + PC_STEP;
    branch_disp_s = branch_disp(branch_off);
    target_s      = dec_pc4_s;
    case (pc_sel)
      SEL_BRANCH: target_s = dec_pc4_s + branch_disp_s;
      SEL_JUMP:   target_s = {dec_pc4_s[WIDTH-1:28], jump_target, 2'b00};
      SEL_REG:    target_s = {reg_target[WIDTH-1:2], 2'b00};
      SEL_SEQ:    target_s = dec_pc4_s;
      default:    target_s = dec_pc4_s;
    endcase
  end

  // An acknowledge only counts while a request is actually outstanding.
  assign ack_s = imem_ack & imem_req_r;

  // Next-state and next-register values; every target holds by default.
  always_comb begin
    next_state_s    = state_r;
    pc_next_s       = pc_r;
    redir_pc_next_s = redir_pc_r;
    dec_pc_next_s   = dec_pc_r;
    flush_next_s    = 1'b0;
    case (state_r)
      S_START: begin
        if (stall) begin
          next_state_s = S_IDLE;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_FETCH: begin
        if (redirect_s) begin
          if (ack_s) begin
            // The returning instruction is wrong-path: drop it, jump now.
            pc_next_s    = target_s;
            flush_next_s = 1'b1;
          end else begin
            // Address must stay stable until the ack; park the target.
            redir_pc_next_s = target_s;
            next_state_s    = S_PEND;
          end
        end else if (ack_s) begin
          dec_pc_next_s = pc_r;
          pc_next_s     = pc_r + PC_STEP;
          if (stall) begin
            next_state_s = S_IDLE;
          end else begin
            next_state_s = S_FETCH;
          end
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_PEND: begin
        // Further redirects are ignored until the stale fetch drains.
        if (ack_s) begin
          pc_next_s    = redir_pc_r;
          flush_next_s = 1'b1;
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_PEND;
        end
      end
      S_IDLE: begin
        if (redirect_s) begin
          pc_next_s    = target_s;
          flush_next_s = 1'b1;
        end else begin
          pc_next_s = pc_r;
        end
        if (stall) begin
          next_state_s = S_IDLE;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      default: begin
        next_state_s = S_START;
      end
    endcase
  end

  // State, PC and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= S_START;
      pc_r       <= RESET_PC;
      redir_pc_r <= RESET_PC;
      dec_pc_r   <= RESET_PC;
      imem_req_r <= 1'b0;
      flush_r    <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      pc_r       <= pc_next_s;
      redir_pc_r <= redir_pc_next_s;
      dec_pc_r   <= dec_pc_next_s;
      imem_req_r <= (next_state_s == S_FETCH) || (next_state_s == S_PEND);
      flush_r    <= flush_next_s;
    end
  end

  assign imem_req    = imem_req_r;
  assign imem_addr   = pc_r;
  assign dec_pc      = dec_pc_r;
  assign flush       = flush_r;
  assign fetch_valid = imem_ack & imem_req_r & (state_r == S_FETCH) & ~redirect_s;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: sequential fetch, branch/jump/register
// redirects, a redirect held pending across a withheld ack, PC wrap, stall
// and mid-request reset. Expected values are hand-computed constants.
module tb_pc_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic [1:0]  pc_sel;
  logic        sel_valid;
  logic [15:0] branch_off;
  logic [25:0] jump_target;
  logic [31:0] reg_target;
  logic        stall;
  logic        imem_ack;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        fetch_valid;
  logic [31:0] dec_pc;
  logic        flush;

  int tests_run;
  int tests_failed;

  pc_fetch_sequencer #(
    .WIDTH    (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_sel      (pc_sel),
    .sel_valid   (sel_valid),
    .branch_off  (branch_off),
    .jump_target (jump_target),
    .reg_target  (reg_target),
    .stall       (stall),
    .imem_ack    (imem_ack),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .fetch_valid (fetch_valid),
    .dec_pc      (dec_pc),
    .flush       (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    pc_sel       = 2'b00;
    sel_valid    = 1'b0;
    branch_off   = 16'h0000;
    jump_target  = 26'h0;
    reg_target   = 32'h0;
    stall        = 1'b0;
    imem_ack     = 1'b0;

    // Reset state
    cyc();
    cyc();
    chk("rst_req",   {31'd0, imem_req}, 32'd0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_dec",   dec_pc, 32'h0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_fv",    {31'd0, fetch_valid}, 32'd0);

    // Release reset; ack while no request is ignored.
    rst_n    = 1'b1;
    imem_ack = 1'b1;
    #1;
    chk("start_fv", {31'd0, fetch_valid}, 32'd0);
    chk("start_req", {31'd0, imem_req}, 32'd0);
    cyc();

    // Back-to-back fetches with ack every cycle.
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("seq_addr", imem_addr, 32'(4 * i));
      chk("seq_dec",  dec_pc, (i == 0) ? 32'h0 : 32'(4 * (i - 1)));
      chk("seq_fv",   {31'd0, fetch_valid}, 32'd1);
      chk("seq_req",  {31'd0, imem_req}, 32'd1);
      cyc();
    end
    repeat (13) cyc();
    chk("pre_br_addr", imem_addr, 32'h44);
    chk("pre_br_dec",  dec_pc, 32'h40);

    // Branch -2 words with same-cycle ack.
    sel_valid  = 1'b1;
    pc_sel     = 2'b01;
    branch_off = 16'hFFFE;
    #1;
    chk("br_fv", {31'd0, fetch_valid}, 32'd0);
    cyc();
    sel_valid = 1'b0;
    chk("br_addr",  imem_addr, 32'h3C);
    chk("br_flush", {31'd0, flush}, 32'd1);
    chk("br_dec",   dec_pc, 32'h40);
    #1;
    chk("br_next_fv", {31'd0, fetch_valid}, 32'd1);
    cyc();
    chk("br_flush_off", {31'd0, flush}, 32'd0);
    chk("br_dec2",      dec_pc, 32'h3C);
    chk("br_addr2",     imem_addr, 32'h40);

    // Move decode PC to 0x1000_0000, then jump and register redirects.
    sel_valid  = 1'b1;
    pc_sel     = 2'b10;
    reg_target = 32'h1000_0000;
    cyc();
    sel_valid = 1'b0;
    cyc();
    chk("j_setup_dec", dec_pc, 32'h1000_0000);
    sel_valid   = 1'b1;
    pc_sel      = 2'b11;
    jump_target = 26'h0000100;
    #1;
    chk("j_fv", {31'd0, fetch_valid}, 32'd0);
    cyc();
    chk("j_addr",  imem_addr, 32'h1000_0400);
    chk("j_flush", {31'd0, flush}, 32'd1);
    pc_sel     = 2'b10;
    reg_target = 32'h0000_2003;
    cyc();
    chk("jr_addr", imem_addr, 32'h0000_2000);
    pc_sel = 2'b00;
    #1;
    chk("sel00_fv", {31'd0, fetch_valid}, 32'd1);
    cyc();
    chk("sel00_addr",  imem_addr, 32'h2004);
    chk("sel00_dec",   dec_pc, 32'h2000);
    chk("sel00_flush", {31'd0, flush}, 32'd0);

    // Redirect with ack withheld for three cycles; second redirect ignored.
    imem_ack   = 1'b0;
    sel_valid  = 1'b1;
    pc_sel     = 2'b01;
    branch_off = 16'h0010;
    cyc();
    pc_sel      = 2'b11;
    jump_target = 26'h3FF_FFFF;
    chk("pend_addr1", imem_addr, 32'h2004);
    chk("pend_req1",  {31'd0, imem_req}, 32'd1);
    cyc();
    chk("pend_addr2",  imem_addr, 32'h2004);
    chk("pend_flush2", {31'd0, flush}, 32'd0);
    cyc();
    sel_valid = 1'b0;
    imem_ack  = 1'b1;
    #1;
    chk("pend_ack_fv",   {31'd0, fetch_valid}, 32'd0);
    chk("pend_ack_addr", imem_addr, 32'h2004);
    cyc();
    chk("pend_tgt_addr",  imem_addr, 32'h2044);
    chk("pend_tgt_flush", {31'd0, flush}, 32'd1);
    chk("pend_tgt_dec",   dec_pc, 32'h2000);

    // PC wrap at the top of the address space.
    sel_valid  = 1'b1;
    pc_sel     = 2'b10;
    reg_target = 32'hFFFF_FFFF;
    cyc();
    sel_valid = 1'b0;
    chk("wrap_pre", imem_addr, 32'hFFFF_FFFC);
    #1;
    chk("wrap_fv", {31'd0, fetch_valid}, 32'd1);
    cyc();
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_dec",  dec_pc, 32'hFFFF_FFFC);

    // Stall: one fetch accepted, request drops, idle redirect, resume.
    stall = 1'b1;
    #1;
    chk("stall_fv", {31'd0, fetch_valid}, 32'd1);
    cyc();
    chk("stall_req",  {31'd0, imem_req}, 32'd0);
    chk("stall_addr", imem_addr, 32'h4);
    chk("stall_dec",  dec_pc, 32'h0);
    sel_valid  = 1'b1;
    pc_sel     = 2'b10;
    reg_target = 32'h0000_0500;
    #1;
    chk("idle_fv", {31'd0, fetch_valid}, 32'd0);
    cyc();
    sel_valid = 1'b0;
    chk("idle_addr",  imem_addr, 32'h500);
    chk("idle_flush", {31'd0, flush}, 32'd1);
    chk("idle_req",   {31'd0, imem_req}, 32'd0);
    stall    = 1'b0;
    imem_ack = 1'b0;
    cyc();
    chk("resume_req",   {31'd0, imem_req}, 32'd1);
    chk("resume_addr",  imem_addr, 32'h500);
    chk("resume_flush", {31'd0, flush}, 32'd0);

    // Reset in the middle of an outstanding request; late ack ignored.
    rst_n = 1'b0;
    cyc();
    imem_ack = 1'b1;
    #1;
    chk("mrst_req",  {31'd0, imem_req}, 32'd0);
    chk("mrst_addr", imem_addr, 32'h0);
    chk("mrst_fv",   {31'd0, fetch_valid}, 32'd0);
    chk("mrst_dec",  dec_pc, 32'h0);
    rst_n = 1'b1;
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
